// File: rtl/sr_func_sched_pkg.sv
// Shared types and helpers for the function-unit issue/hazard/writeback controller.
// The FS_* state encodings are the ones the CPU-wide header is expected to carry.
package sr_func_sched_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_LAUNCH = 2'd1,
        FS_WAIT   = 2'd2,
        FS_WB     = 2'd3
    } fs_state_t;

    // x0 is never a real dependency, so a match on it is ignored.
    function automatic logic reg_match(input logic [REG_AW-1:0] a,
                                       input logic [REG_AW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/sr_func_sched_if.sv
// Decode/CPU, function-unit and register-file-port signals of the scheduler.
// slave is the scheduler side, master is the decode/datapath/function-unit side.
interface sr_func_sched_if;
    import sr_func_sched_pkg::*;

    logic              issue_valid;
    logic [REG_AW-1:0] issue_rd;
    logic [XLEN-1:0]   issue_a;
    logic [XLEN-1:0]   issue_b;
    logic [REG_AW-1:0] cpu_rs1;
    logic [REG_AW-1:0] cpu_rs2;
    logic              cpu_use_rs1;
    logic              cpu_use_rs2;
    logic              cpu_we;
    logic [REG_AW-1:0] cpu_rd;
    logic [XLEN-1:0]   cpu_wd;
    logic              stall;
    logic              fu_start;
    logic              fu_rst;
    logic [XLEN-1:0]   fu_a;
    logic [XLEN-1:0]   fu_b;
    logic              fu_busy;
    logic [XLEN-1:0]   fu_result;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              wb_sel;
    logic              pending;
    logic [REG_AW-1:0] pending_rd;
    logic              err;

    modport slave (
        input  issue_valid, issue_rd, issue_a, issue_b,
        input  cpu_rs1, cpu_rs2, cpu_use_rs1, cpu_use_rs2, cpu_we, cpu_rd, cpu_wd,
        input  fu_busy, fu_result,
        output stall, fu_start, fu_rst, fu_a, fu_b,
        output wb_we, wb_rd, wb_data, wb_sel, pending, pending_rd, err
    );

    modport master (
        output issue_valid, issue_rd, issue_a, issue_b,
        output cpu_rs1, cpu_rs2, cpu_use_rs1, cpu_use_rs2, cpu_we, cpu_rd, cpu_wd,
        output fu_busy, fu_result,
        input  stall, fu_start, fu_rst, fu_a, fu_b,
        input  wb_we, wb_rd, wb_data, wb_sel, pending, pending_rd, err
    );

endinterface

// File: rtl/sr_func_hazard.sv
// Combinational stall generation: structural, RAW, WAW and register-file port conflict
// against the single outstanding function-unit operation.
module sr_func_hazard
    import sr_func_sched_pkg::*;
(
    input  logic              i_issue_valid,
    input  logic              i_pending,
    input  logic              i_in_wb,
    input  logic [REG_AW-1:0] i_pending_rd,
    input  logic [REG_AW-1:0] i_cpu_rs1,
    input  logic [REG_AW-1:0] i_cpu_rs2,
    input  logic              i_cpu_use_rs1,
    input  logic              i_cpu_use_rs2,
    input  logic              i_cpu_we,
    input  logic [REG_AW-1:0] i_cpu_rd,
    output logic              o_stall
);

    logic w_struct, w_raw, w_waw, w_port;

    assign w_struct = i_issue_valid & i_pending;
    assign w_raw    = i_pending & ((i_cpu_use_rs1 & reg_match(i_cpu_rs1, i_pending_rd)) |
                                   (i_cpu_use_rs2 & reg_match(i_cpu_rs2, i_pending_rd)));
    assign w_waw    = i_pending & i_cpu_we & reg_match(i_cpu_rd, i_pending_rd);
    // The function-unit result owns the write port in WB, even when rd is x0.
    assign w_port   = i_in_wb & i_cpu_we;

    assign o_stall  = w_struct | w_raw | w_waw | w_port;

endmodule

// File: rtl/sr_func_sched.sv
// Issue/launch FSM, timeout counter, operand/result registers and register-file
// write-port mux for the single multi-cycle function unit.
module sr_func_sched
    import sr_func_sched_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    sr_func_sched_if.slave bus
);

    localparam int              CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT);

    fs_state_t         r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_fu_a, r_fu_b, r_result;
    logic [REG_AW-1:0] r_pend_rd;
    logic              r_err;

    logic w_stall, w_accept, w_timeout, w_in_wb, w_in_wait, w_pending;
    logic w_fu_start, w_fu_rst;

    assign w_pending = (r_state != FS_IDLE);
    assign w_in_wb   = (r_state == FS_WB);
    assign w_in_wait = (r_state == FS_WAIT);
    assign w_accept  = bus.issue_valid & ~w_stall;
    assign w_timeout = w_in_wait & bus.fu_busy & (r_cnt == CNT_MAX);

    sr_func_hazard u_hazard (
        .i_issue_valid (bus.issue_valid),
        .i_pending     (w_pending),
        .i_in_wb       (w_in_wb),
        .i_pending_rd  (r_pend_rd),
        .i_cpu_rs1     (bus.cpu_rs1),
        .i_cpu_rs2     (bus.cpu_rs2),
        .i_cpu_use_rs1 (bus.cpu_use_rs1),
        .i_cpu_use_rs2 (bus.cpu_use_rs2),
        .i_cpu_we      (bus.cpu_we),
        .i_cpu_rd      (bus.cpu_rd),
        .o_stall       (w_stall)
    );

    always_comb begin
        w_next     = r_state;
        w_fu_start = 1'b0;
        // Abort reset pulse is the deciding WAIT cycle only, not the IDLE that follows.
        w_fu_rst   = rst | w_timeout;
        case (r_state)
            FS_IDLE:   if (w_accept) w_next = FS_LAUNCH;
            FS_LAUNCH: begin
                w_fu_start = 1'b1;
                w_next     = FS_WAIT;
            end
            FS_WAIT: begin
                if (!bus.fu_busy)  w_next = FS_WB;
                else if (w_timeout) w_next = FS_IDLE;
            end
            FS_WB:     w_next = FS_IDLE;
            default:   w_next = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FS_IDLE;
            r_cnt     <= '0;
            r_fu_a    <= '0;
            r_fu_b    <= '0;
            r_result  <= '0;
            r_pend_rd <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == FS_IDLE && w_accept) begin
                r_fu_a    <= bus.issue_a;
                r_fu_b    <= bus.issue_b;
                r_pend_rd <= bus.issue_rd;
            end
            if (r_state == FS_LAUNCH)
                r_cnt <= '0;
            else if (w_in_wait && bus.fu_busy && !w_timeout)
                r_cnt <= r_cnt + CW'(1);
            if (w_in_wait && !bus.fu_busy)
                r_result <= bus.fu_result;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    assign bus.stall      = w_stall;
    assign bus.fu_start   = w_fu_start;
    assign bus.fu_rst     = w_fu_rst;
    assign bus.fu_a       = r_fu_a;
    assign bus.fu_b       = r_fu_b;
    assign bus.pending    = w_pending;
    assign bus.pending_rd = r_pend_rd;
    assign bus.err        = r_err;

    assign bus.wb_sel     = w_in_wb;
    assign bus.wb_rd      = w_in_wb ? r_pend_rd : bus.cpu_rd;
    assign bus.wb_data    = w_in_wb ? r_result  : bus.cpu_wd;
    assign bus.wb_we      = w_in_wb ? (r_pend_rd != '0) : (bus.cpu_we & ~w_stall);

endmodule

// File: tb/tb_sr_func_sched.sv
// Directed bench: every register-file write is checked by a scoreboard monitor,
// stall/launch/abort behaviour is checked cycle by cycle by the stimulus.
module tb_sr_func_sched;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        sel;
    } wb_exp_t;

    logic clk, rst;
    sr_func_sched_if bus();

    sr_func_sched #(.TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int      n_cmp = 0;
    int      n_bad = 0;
    wb_exp_t sb[$];

    // Function-unit model: busy for m_len cycles after start, or forever when stuck.
    int          m_len   = 1;
    logic        m_stuck = 1'b0;
    logic [31:0] m_res   = 32'h0;
    int          m_left;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst || bus.fu_rst) begin
            bus.fu_busy   <= 1'b0;
            bus.fu_result <= 32'h0;
            m_left        <= 0;
        end else if (bus.fu_start) begin
            bus.fu_busy   <= 1'b1;
            bus.fu_result <= 32'hDEAD_BEEF;
            m_left        <= m_len - 1;
        end else if (bus.fu_busy && !m_stuck) begin
            if (m_left == 0) begin
                bus.fu_busy   <= 1'b0;
                bus.fu_result <= m_res;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write on the register-file port must be the next expected one.
    always @(negedge clk) begin
        wb_exp_t e;
        if (!rst && bus.wb_we) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_wb: got rd %0d data %0h, expected no write at %0t",
                         bus.wb_rd, bus.wb_data, $time);
            end else begin
                e = sb.pop_front();
                chk("wb_rd",   32'(bus.wb_rd),   32'(e.rd));
                chk("wb_data", bus.wb_data,      e.data);
                chk("wb_sel",  32'(bus.wb_sel),  32'(e.sel));
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic clear_in();
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.issue_a     = '0;
        bus.issue_b     = '0;
        bus.cpu_rs1     = '0;
        bus.cpu_rs2     = '0;
        bus.cpu_use_rs1 = 1'b0;
        bus.cpu_use_rs2 = 1'b0;
        bus.cpu_we      = 1'b0;
        bus.cpu_rd      = '0;
        bus.cpu_wd      = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = rd;
        bus.issue_a     = a;
        bus.issue_b     = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_in();
        repeat (2) @(posedge clk);
        #1;
        neg();
        chk("rst_fu_rst",   32'(bus.fu_rst),     1);
        chk("rst_stall",    32'(bus.stall),      0);
        chk("rst_pending",  32'(bus.pending),    0);
        chk("rst_fu_start", 32'(bus.fu_start),   0);
        chk("rst_wb_we",    32'(bus.wb_we),      0);
        chk("rst_err",      32'(bus.err),        0);
        chk("rst_fu_a",     bus.fu_a,            0);
        chk("rst_prd",      32'(bus.pending_rd), 0);
        nxt();
        rst = 1'b0;
        neg();
        chk("fu_rst_low",   32'(bus.fu_rst),     0);
        nxt();

        // Basic op rd=5, 7*3=21, busy 4 cycles; hazards exercised during WAIT.
        m_len = 4; m_res = 32'd21;
        issue(5'd5, 32'd7, 32'd3);
        sb.push_back('{rd: 5'd5, data: 32'd21, sel: 1'b1});
        neg();
        chk("t1_accept_stall", 32'(bus.stall),    0);
        chk("t1_T_fu_start",   32'(bus.fu_start), 0);
        nxt(); clear_in();
        neg();
        chk("t1_T1_fu_start",  32'(bus.fu_start), 1);
        chk("t1_T1_pending",   32'(bus.pending),  1);
        chk("t1_pending_rd",   32'(bus.pending_rd), 5);
        chk("t1_fu_a",         bus.fu_a, 7);
        chk("t1_fu_b",         bus.fu_b, 3);
        nxt(); bus.cpu_use_rs2 = 1'b1; bus.cpu_rs2 = 5'd5;
        neg();
        chk("t1_raw_stall",    32'(bus.stall),    1);
        chk("t1_T2_fu_start",  32'(bus.fu_start), 0);
        nxt(); clear_in();
        bus.cpu_use_rs1 = 1'b1; bus.cpu_rs1 = 5'd6;
        bus.cpu_use_rs2 = 1'b1; bus.cpu_rs2 = 5'd7;
        neg();
        chk("t1_indep_stall",  32'(bus.stall), 0);
        chk("t1_indep_wb_we",  32'(bus.wb_we), 0);
        nxt(); clear_in(); issue(5'd8, 32'd1, 32'd1);
        neg();
        chk("t1_struct_stall", 32'(bus.stall), 1);
        nxt(); clear_in();
        bus.cpu_we = 1'b1; bus.cpu_rd = 5'd5; bus.cpu_wd = 32'hAA;
        neg();
        chk("t1_waw_stall",    32'(bus.stall),    1);
        chk("t1_waw_wb_we",    32'(bus.wb_we),    0);
        chk("t1_no_relaunch",  32'(bus.fu_start), 0);
        nxt(); clear_in(); bus.cpu_use_rs1 = 1'b1; bus.cpu_rs1 = 5'd5;
        neg();
        chk("t1_W_stall",      32'(bus.stall),   1);
        chk("t1_W_pending",    32'(bus.pending), 1);
        nxt();
        neg();
        chk("t1_WB_stall",     32'(bus.stall),   1);
        chk("t1_WB_sel",       32'(bus.wb_sel),  1);
        nxt();
        neg();
        chk("t1_W2_unstall",   32'(bus.stall),   0);
        chk("t1_W2_pending",   32'(bus.pending), 0);
        nxt(); clear_in();

        // WB cycle collides with a CPU write to x9: x9 goes one cycle later.
        m_len = 1; m_res = 32'h55;
        issue(5'd3, 32'd1, 32'd2);
        sb.push_back('{rd: 5'd3, data: 32'h55, sel: 1'b1});
        nxt(); clear_in();
        nxt();
        nxt();
        neg();
        chk("t2_W_sel",        32'(bus.wb_sel),  0);
        chk("t2_W_pending",    32'(bus.pending), 1);
        nxt();
        bus.cpu_we = 1'b1; bus.cpu_rd = 5'd9; bus.cpu_wd = 32'h99;
        sb.push_back('{rd: 5'd9, data: 32'h99, sel: 1'b0});
        neg();
        chk("t2_port_stall",   32'(bus.stall), 1);
        chk("t2_WB_rd",        32'(bus.wb_rd), 3);
        nxt();
        neg();
        chk("t2_x9_stall",     32'(bus.stall),  0);
        chk("t2_x9_sel",       32'(bus.wb_sel), 0);
        nxt(); clear_in();

        // rd=0 op and x0 dependencies: nothing stalls, no FU write.
        m_len = 2; m_res = 32'h77;
        issue(5'd0, 32'd4, 32'd5);
        nxt(); clear_in();
        nxt();
        bus.cpu_use_rs1 = 1'b1; bus.cpu_rs1 = 5'd0;
        bus.cpu_we = 1'b1; bus.cpu_rd = 5'd0; bus.cpu_wd = 32'h1234;
        sb.push_back('{rd: 5'd0, data: 32'h1234, sel: 1'b0});
        neg();
        chk("t3_x0_stall",     32'(bus.stall), 0);
        chk("t3_x0_wb_we",     32'(bus.wb_we), 1);
        nxt(); bus.cpu_we = 1'b0;
        neg();
        chk("t3_x0_rd_stall",  32'(bus.stall), 0);
        nxt();
        neg();
        chk("t3_W_pending",    32'(bus.pending), 1);
        nxt();
        neg();
        chk("t3_WB_sel",       32'(bus.wb_sel), 1);
        chk("t3_WB_we",        32'(bus.wb_we),  0);
        chk("t3_WB_stall",     32'(bus.stall),  0);
        nxt();
        neg();
        chk("t3_idle",         32'(bus.pending), 0);
        nxt(); clear_in();

        // Timeout: busy stuck, abort in the 9th WAIT cycle.
        m_stuck = 1'b1;
        issue(5'd4, 32'h11, 32'h22);
        nxt(); clear_in();
        for (int i = 0; i < 8; i++) begin
            nxt();
            neg();
            chk("t4_wait_fu_rst", 32'(bus.fu_rst), 0);
        end
        nxt();
        neg();
        chk("t4_abort_fu_rst", 32'(bus.fu_rst),  1);
        chk("t4_abort_err",    32'(bus.err),     0);
        chk("t4_abort_pend",   32'(bus.pending), 1);
        nxt();
        neg();
        chk("t4_post_fu_rst",  32'(bus.fu_rst),  0);
        chk("t4_post_err",     32'(bus.err),     1);
        chk("t4_post_pend",    32'(bus.pending), 0);
        nxt();

        // New op, then reset mid-WAIT: everything clears, err included.
        issue(5'd6, 32'h33, 32'h44);
        nxt(); clear_in();
        nxt();
        nxt();
        neg();
        chk("t5_err_sticky",   32'(bus.err), 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_fu_rst",   32'(bus.fu_rst), 1);
        nxt();
        rst = 1'b0;
        neg();
        chk("t5_stall",    32'(bus.stall),      0);
        chk("t5_fu_start", 32'(bus.fu_start),   0);
        chk("t5_fu_rst",   32'(bus.fu_rst),     0);
        chk("t5_fu_a",     bus.fu_a,            0);
        chk("t5_fu_b",     bus.fu_b,            0);
        chk("t5_wb_we",    32'(bus.wb_we),      0);
        chk("t5_wb_rd",    32'(bus.wb_rd),      0);
        chk("t5_wb_data",  bus.wb_data,         0);
        chk("t5_wb_sel",   32'(bus.wb_sel),     0);
        chk("t5_pending",  32'(bus.pending),    0);
        chk("t5_prd",      32'(bus.pending_rd), 0);
        chk("t5_err",      32'(bus.err),        0);
        repeat (4) begin
            nxt();
            neg();
            chk("t5_stay_idle", 32'(bus.pending), 0);
        end

        chk("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
